// File: rtl/sr_address.sv
// One word row of the SRAM macro: byte-writable storage with a registered,
// zero-when-idle read port so that rows can be OR-combined at the top level.
module sr_address #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                  retrieve_clk,
  input  logic                  rst_n,
  input  logic                  WL,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     datain,
  output logic [DATA_W-1:0]     dataout,
  output logic                  dout_valid,
  output logic                  f_ready
);

  localparam int NUM_BYTES = DATA_W / 8;

  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] word_d;
  logic              access;

  // The row only reacts to its word line once it has come out of reset.
  assign access = f_ready & ~WL;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    word_d = word_q;
    if (access && we) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (be[k]) word_d[8*k +: 8] = datain[8*k +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge retrieve_clk or negedge rst_n) begin
    if (!rst_n) f_ready <= 1'b0;
    else        f_ready <= 1'b1;
  end

  // NOTE: the stored word is a single register, not an array, so it is
  // cheap to reset and gives a known RESET_VAL after power-up.
  always_ff @(posedge retrieve_clk or negedge rst_n) begin
    if (!rst_n) word_q <= RESET_VAL;
    else        word_q <= word_d;
  end

  // Read data is zero on every edge that is not a read, including writes.
  always_ff @(posedge retrieve_clk or negedge rst_n) begin
    if (!rst_n) begin
      dataout    <= '0;
      dout_valid <= 1'b0;
    end else if (access && !we) begin
      dataout    <= word_q;
      dout_valid <= 1'b1;
    end else begin
      dataout    <= '0;
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sr_address.sv
// Directed bench for sr_address: reset, full and byte-masked writes,
// deselected bus activity, back-to-back reads and reset during a read.
module tb_sr_address;

  localparam int DATA_W = 32;

  logic              retrieve_clk = 1'b0;
  logic              rst_n;
  logic              WL;
  logic              we;
  logic [3:0]        be;
  logic [DATA_W-1:0] datain;
  logic [DATA_W-1:0] dataout;
  logic              dout_valid;
  logic              f_ready;

  int total = 0;
  int bad   = 0;

  sr_address #(.DATA_W(DATA_W), .RESET_VAL('0)) dut (
    .retrieve_clk (retrieve_clk),
    .rst_n        (rst_n),
    .WL           (WL),
    .we           (we),
    .be           (be),
    .datain       (datain),
    .dataout      (dataout),
    .dout_valid   (dout_valid),
    .f_ready      (f_ready)
  );

  always #5 retrieve_clk = ~retrieve_clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge retrieve_clk);
    #1;
  endtask

  task automatic drive(input logic wl_v, input logic we_v, input logic [3:0] be_v,
                       input logic [DATA_W-1:0] d_v);
    WL = wl_v; we = we_v; be = be_v; datain = d_v;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 4'h0, '0);
    #2;
    check("rst_dataout", dataout, '0);
    check("rst_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_ready", {31'd0, f_ready}, 32'd0);
    step(); step();
    rst_n = 1'b1;

    // Idle for three edges after release.
    step();
    check("idle_ready_first_edge", {31'd0, f_ready}, 32'd1);
    for (int i = 0; i < 2; i++) step();
    check("idle_dataout", dataout, '0);
    check("idle_valid", {31'd0, dout_valid}, 32'd0);

    // Stored word after reset reads back as zero.
    drive(1'b0, 1'b0, 4'h0, '0); step();
    check("read_reset_val", dataout, 32'h0000_0000);
    check("read_reset_valid", {31'd0, dout_valid}, 32'd1);

    // Full write then read.
    drive(1'b0, 1'b1, 4'hF, 32'hDEADBEEF); step();
    check("write_edge_valid", {31'd0, dout_valid}, 32'd0);
    check("write_edge_dataout", dataout, '0);
    drive(1'b0, 1'b0, 4'h0, '0); step();
    check("full_read", dataout, 32'hDEADBEEF);
    check("full_read_valid", {31'd0, dout_valid}, 32'd1);
    drive(1'b1, 1'b0, 4'h0, '0); step();
    check("deselect_dataout", dataout, '0);
    check("deselect_valid", {31'd0, dout_valid}, 32'd0);

    // Byte-enable merge: bytes 0 and 2 replaced.
    drive(1'b0, 1'b1, 4'b0101, 32'h11223344); step();
    drive(1'b0, 1'b0, 4'hF, 32'hFFFFFFFF); step();
    check("be_merge", dataout, 32'hDE22BE44);

    // Deselected row ignores a full write on the bus.
    drive(1'b1, 1'b1, 4'hF, 32'hFFFFFFFF); step();
    check("deselect_write_dataout", dataout, '0);
    drive(1'b0, 1'b0, 4'h0, '0); step();
    check("deselect_write_kept", dataout, 32'hDE22BE44);

    // be=0 write is a no-op.
    drive(1'b0, 1'b1, 4'h0, 32'h55555555); step();
    drive(1'b0, 1'b0, 4'h0, '0); step();
    check("be_zero_noop", dataout, 32'hDE22BE44);

    // Back-to-back reads.
    for (int i = 0; i < 3; i++) begin
      step();
      check("b2b_valid", {31'd0, dout_valid}, 32'd1);
      check("b2b_data", dataout, 32'hDE22BE44);
    end

    // Top-byte write immediately followed by a read.
    drive(1'b0, 1'b1, 4'b1000, 32'hA5000000); step();
    drive(1'b0, 1'b0, 4'h0, '0); step();
    check("write_then_read", dataout, 32'hA522BE44);

    // Reset asserted while dout_valid is high.
    check("pre_reset_valid", {31'd0, dout_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_dataout", dataout, '0);
    check("async_rst_valid", {31'd0, dout_valid}, 32'd0);
    check("async_rst_ready", {31'd0, f_ready}, 32'd0);
    drive(1'b0, 1'b1, 4'hF, 32'h12345678); step();
    drive(1'b0, 1'b0, 4'h0, '0);
    rst_n = 1'b1;
    // First edge after release only raises f_ready; the read is ignored.
    step();
    check("post_rst_ready", {31'd0, f_ready}, 32'd1);
    check("post_rst_ignored_valid", {31'd0, dout_valid}, 32'd0);
    step();
    check("post_rst_read", dataout, 32'h0000_0000);
    check("post_rst_read_valid", {31'd0, dout_valid}, 32'd1);
    drive(1'b1, 1'b0, 4'h0, '0); step();
    check("final_idle_valid", {31'd0, dout_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
